pattern_prbs_checker: RTL and testbench

- Receive-side checker that sits directly downstream of the PRBS pattern generator and consumes its 8-bit output stream.
- Verifies the leading pattern phase: the 32-bit `seq` word, sent MSB byte first, repeated `n` times.
- Then locks onto the PRBS-15 tail with a self-synchronising checker and reports bit errors.
- Provides pass/fail and lock status to the test/status logic of the pattern-detector subsystem.

---
 rtl/pattern_prbs_checker.sv | 169 ++++++++++++++++
 tb/tb_pattern_prbs_checker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_prbs_checker.sv
// Receive-side checker for the PRBS pattern generator stream.
// First verifies n repetitions of a 32-bit pattern word (MSB byte first),
// then seeds a 15-bit history and checks the PRBS-15 tail bit by bit,
// using a self-synchronising predictor fed with the received bits.
module pattern_prbs_checker #(
    parameter int ERR_W      = 16,
    parameter int SEED_BYTES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      seq,
    input  logic [7:0]       n,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             pattern_done,
    output logic             pattern_err,
    output logic [7:0]       pattern_mis_cnt,
    output logic             prbs_lock,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PATTERN = 2'd1,
        SEED    = 2'd2,
        CHECK   = 2'd3
    } state_t;

    localparam int SC_W = $clog2(SEED_BYTES + 1);

    state_t           state_q, state_d;
    logic [31:0]      seq_q, seq_d;
    logic [7:0]       n_q, n_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [7:0]       rep_q, rep_d;
    logic [SC_W-1:0]  seed_cnt_q, seed_cnt_d;
    logic [14:0]      hist_q, hist_d;
    logic             pattern_done_q, pattern_done_d;
    logic             pattern_err_q, pattern_err_d;
    logic [7:0]       mis_cnt_q, mis_cnt_d;
    logic             lock_q, lock_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             mis;
    logic [7:0]       exp_byte;
    logic [3:0]       errs;
    logic [14:0]      h;
    logic             rx_bit;
    logic [ERR_W:0]   err_sum;

    // Next-state and next-output computation for one accepted byte
    always_comb begin
        state_d        = state_q;
        seq_d          = seq_q;
        n_d            = n_q;
        byte_idx_d     = byte_idx_q;
        rep_d          = rep_q;
        seed_cnt_d     = seed_cnt_q;
        hist_d         = hist_q;
        pattern_done_d = pattern_done_q;
        pattern_err_d  = pattern_err_q;
        mis_cnt_d      = mis_cnt_q;
        lock_d         = lock_q;
        err_cnt_d      = err_cnt_q;
        mis            = 1'b0;
        errs           = '0;
        h              = hist_q;
        rx_bit         = 1'b0;
        err_sum        = '0;
        // index 0 selects seq[31:24]: bit offset is (3-idx)*8
        exp_byte       = seq_q[{~byte_idx_q, 3'b000} +: 8];

        if (din_valid) begin
            case (state_q)
                IDLE: begin
                    seq_d = seq;
                    n_d   = n;
                    if (n != 8'd0) begin
                        mis        = (din != seq[31:24]);
                        byte_idx_d = 2'd1;
                        rep_d      = '0;
                        state_d    = PATTERN;
                    end else begin
                        pattern_done_d = 1'b1;
                        hist_d         = {hist_q[6:0], din};
                        seed_cnt_d     = SC_W'(1);
                        state_d        = SEED;
                    end
                end
                PATTERN: begin
                    mis        = (din != exp_byte);
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        rep_d = rep_q + 8'd1;
                        if (rep_q == n_q - 8'd1) begin
                            pattern_done_d = 1'b1;
                            state_d        = SEED;
                        end
                    end
                end
                SEED: begin
                    hist_d     = {hist_q[6:0], din};
                    seed_cnt_d = seed_cnt_q + SC_W'(1);
                    if (seed_cnt_q == SC_W'(SEED_BYTES - 1))
                        state_d = CHECK;
                end
                CHECK: begin
                    for (int unsigned i = 0; i < 8; i++) begin
                        rx_bit = din[3'(7 - i)];
                        if ((h[13] ^ h[14]) != rx_bit)
                            errs = errs + 4'd1;
                        h = {h[13:0], rx_bit};
                    end
                    hist_d    = h;
                    err_sum   = {1'b0, err_cnt_q} + (ERR_W+1)'(errs);
                    err_cnt_d = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
                    lock_d    = (errs == 4'd0);
                end
                default: state_d = IDLE;
            endcase

            if (mis) begin
                pattern_err_d = 1'b1;
                if (mis_cnt_q != '1)
                    mis_cnt_d = mis_cnt_q + 8'd1;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            seq_q          <= '0;
            n_q            <= '0;
            byte_idx_q     <= '0;
            rep_q          <= '0;
            seed_cnt_q     <= '0;
            hist_q         <= '0;
            pattern_done_q <= 1'b0;
            pattern_err_q  <= 1'b0;
            mis_cnt_q      <= '0;
            lock_q         <= 1'b0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            seq_q          <= seq_d;
            n_q            <= n_d;
            byte_idx_q     <= byte_idx_d;
            rep_q          <= rep_d;
            seed_cnt_q     <= seed_cnt_d;
            hist_q         <= hist_d;
            pattern_done_q <= pattern_done_d;
            pattern_err_q  <= pattern_err_d;
            mis_cnt_q      <= mis_cnt_d;
            lock_q         <= lock_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign pattern_done    = pattern_done_q;
    assign pattern_err     = pattern_err_q;
    assign pattern_mis_cnt = mis_cnt_q;
    assign prbs_lock       = lock_q;
    assign err_cnt         = err_cnt_q;
    assign state           = state_q;

endmodule

// File: tb/tb_pattern_prbs_checker.sv
// Self-checking bench for pattern_prbs_checker: a stream-level model
// (byte count, received-bit queue) predicts every output each cycle.
module tb_pattern_prbs_checker;

    localparam int ERR_W      = 16;
    localparam int SEED_BYTES = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      seq;
    logic [7:0]       n;
    logic [7:0]       din;
    logic             din_valid;
    logic             pattern_done;
    logic             pattern_err;
    logic [7:0]       pattern_mis_cnt;
    logic             prbs_lock;
    logic [ERR_W-1:0] err_cnt;
    logic [1:0]       state;

    pattern_prbs_checker #(.ERR_W(ERR_W), .SEED_BYTES(SEED_BYTES)) dut (
        .clk(clk), .rst(rst), .seq(seq), .n(n), .din(din), .din_valid(din_valid),
        .pattern_done(pattern_done), .pattern_err(pattern_err),
        .pattern_mis_cnt(pattern_mis_cnt), .prbs_lock(prbs_lock),
        .err_cnt(err_cnt), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    int          m_cnt;
    logic [31:0] m_seq;
    int          m_n;
    bit          m_bits[$];
    int          m_mis;
    bit          m_perr;
    bit          m_lock;
    int          m_err;

    // reference PRBS-15 generator
    bit          g_bits[$];

    task automatic gen_reset();
        g_bits = {};
        for (int i = 0; i < 15; i++) g_bits.push_back(1'b1);
    endtask

    task automatic gen_byte(output logic [7:0] b);
        int k;
        for (int i = 0; i < 8; i++) begin
            k = g_bits.size();
            g_bits.push_back(g_bits[k-14] ^ g_bits[k-15]);
        end
        // bytes are taken from bit 0 onward; the 15 seed bits belong to the stream
        k = g_bits.size() - 8 - 15;
        b = '0;
        for (int i = 0; i < 8; i++) b[7-i] = g_bits[k+i];
    endtask

    task automatic model_reset();
        m_cnt = 0; m_seq = '0; m_n = 0; m_bits = {};
        m_mis = 0; m_perr = 0; m_lock = 0; m_err = 0;
    endtask

    task automatic model_accept(input logic [7:0] b);
        logic [7:0] e;
        int         k;
        int         be;
        if (m_cnt == 0) begin
            m_seq = seq;
            m_n   = int'(n);
        end
        if (m_cnt < 4 * m_n) begin
            e = 8'((m_seq >> (8 * (3 - (m_cnt % 4)))) & 32'hFF);
            if (e != b) begin
                m_perr = 1;
                if (m_mis < 255) m_mis++;
            end
        end else begin
            be = 0;
            for (int i = 7; i >= 0; i--) begin
                k = m_bits.size();
                if (k >= 8 * SEED_BYTES && ((m_bits[k-14] ^ m_bits[k-15]) != b[i])) be++;
                m_bits.push_back(b[i]);
            end
            if (m_cnt - 4 * m_n >= SEED_BYTES) begin
                m_err  = (m_err + be > 65535) ? 65535 : m_err + be;
                m_lock = (be == 0);
            end
        end
        m_cnt++;
    endtask

    function automatic int model_state();
        if (m_cnt == 0) return 0;
        if (m_cnt < 4 * m_n) return 1;
        if (m_cnt < 4 * m_n + SEED_BYTES) return 2;
        return 3;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("state",           state,           model_state());
        check("pattern_done",    pattern_done,    (m_cnt > 0 && m_cnt >= 4 * m_n) ? 1 : 0);
        check("pattern_err",     pattern_err,     m_perr);
        check("pattern_mis_cnt", pattern_mis_cnt, m_mis);
        check("prbs_lock",       prbs_lock,       m_lock);
        check("err_cnt",         err_cnt,         m_err);
    endtask

    // one clock: drive at negedge, model updates after posedge, compare at next negedge
    task automatic step(input logic v, input logic [7:0] b, input logic r);
        din = b; din_valid = v; rst = r;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else if (v) model_accept(b);
        @(negedge clk);
        din_valid = 1'b0; rst = 1'b0;
        compare_all();
    endtask

    task automatic send_pattern(input logic [31:0] w, input int reps,
                                input int bad1, input logic [7:0] v1,
                                input int bad2, input logic [7:0] v2);
        logic [7:0] b;
        for (int j = 0; j < 4 * reps; j++) begin
            b = 8'((w >> (8 * (3 - (j % 4)))) & 32'hFF);
            if (j + 1 == bad1) b = v1;
            if (j + 1 == bad2) b = v2;
            step(1'b1, b, 1'b0);
            if (j == 0) seq = 32'h12345678;   // must be ignored after latching
        end
    endtask

    task automatic send_prbs(input int nbytes, input int flip_byte, input int flip_bit,
                             input int flip2_byte, input int flip2_bit, input int gap);
        logic [7:0] b;
        gen_reset();
        for (int j = 0; j < nbytes; j++) begin
            gen_byte(b);
            if (j == flip_byte)  b[flip_bit]  = ~b[flip_bit];
            if (j == flip2_byte) b[flip2_bit] = ~b[flip2_bit];
            step(1'b1, b, 1'b0);
            for (int g = 0; g < gap; g++) step(1'b0, 8'h5A, 1'b0);
        end
    endtask

    logic [7:0] gb;

    initial begin
        rst = 1'b1; din = '0; din_valid = 1'b0; seq = '0; n = '0;
        model_reset();
        @(negedge clk);

        // pin the reference generator: seed all ones -> FF FE 00 04
        gen_reset();
        gen_byte(gb); check("gen_b0", gb, 8'hFF);
        gen_byte(gb); check("gen_b1", gb, 8'hFE);
        gen_byte(gb); check("gen_b2", gb, 8'h00);
        gen_byte(gb); check("gen_b3", gb, 8'h04);

        // reset state
        step(1'b0, 8'h00, 1'b1);
        check("rst_state", state, 0);
        check("rst_done",  pattern_done, 0);

        // tests 1-3: clean pattern, PRBS with one flipped bit
        seq = 32'hABCDEF23; n = 8'd5;
        send_pattern(32'hABCDEF23, 5, -1, 8'h00, -1, 8'h00);
        check("t1_done",  pattern_done, 1);
        check("t1_state", state, 2);
        check("t1_mis",   pattern_mis_cnt, 0);
        send_prbs(64, 10, 4, -1, 0, 0);
        check("t3_err3",  err_cnt, 3);
        check("t3_lock",  prbs_lock, 1);
        check("t3_state", state, 3);

        // test 2: clean PRBS
        step(1'b0, 8'h00, 1'b1);
        seq = 32'hABCDEF23; n = 8'd5;
        send_pattern(32'hABCDEF23, 5, -1, 8'h00, -1, 8'h00);
        send_prbs(64, -1, 0, -1, 0, 0);
        check("t2_err0", err_cnt, 0);
        check("t2_lock", prbs_lock, 1);

        // test 4: two corrupted pattern bytes
        step(1'b0, 8'h00, 1'b1);
        seq = 32'hABCDEF23; n = 8'd5;
        send_pattern(32'hABCDEF23, 5, 6, 8'h00, 17, 8'hFF);
        check("t4_perr", pattern_err, 1);
        check("t4_mis",  pattern_mis_cnt, 2);
        check("t4_done", pattern_done, 1);

        // test 5: n=0, without and with gaps
        step(1'b0, 8'h00, 1'b1);
        seq = 32'hABCDEF23; n = 8'd0;
        send_prbs(20, -1, 0, -1, 0, 0);
        check("t5_err0", err_cnt, 0);
        step(1'b0, 8'h00, 1'b1);
        send_prbs(20, -1, 0, -1, 0, 3);
        check("t5g_err0",  err_cnt, 0);
        check("t5g_state", state, 3);

        // test 6: err_cnt=5 (3 + 2 at stream end), then reset with din_valid=1
        step(1'b0, 8'h00, 1'b1);
        seq = 32'hABCDEF23; n = 8'd5;
        send_pattern(32'hABCDEF23, 5, -1, 8'h00, -1, 8'h00);
        send_prbs(64, 10, 4, 62, 6, 0);
        check("t6_err5", err_cnt, 5);
        step(1'b1, 8'hAB, 1'b1);
        check("t6_rst_state", state, 0);
        check("t6_rst_err",   err_cnt, 0);
        seq = 32'hABCDEF23; n = 8'd5;
        send_pattern(32'hABCDEF23, 5, -1, 8'h00, -1, 8'h00);
        check("t6_done", pattern_done, 1);

        // n=255 boundary: 1020 pattern bytes
        step(1'b0, 8'h00, 1'b1);
        seq = 32'h0F1E2D3C; n = 8'd255;
        send_pattern(32'h0F1E2D3C, 255, 1019, 8'h77, -1, 8'h00);
        check("n255_done", pattern_done, 1);
        check("n255_mis",  pattern_mis_cnt, 1);
        send_prbs(4, -1, 0, -1, 0, 0);
        check("n255_state", state, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
